// File: rtl/verificador_senha.sv
// verificador_senha: lock controller checking keypad packets against user/master passwords,
// with failed-attempt lockout and a programming mode that replaces the user password.
module verificador_senha #(
    parameter logic [79:0] SENHA_PADRAO = {{16{4'hF}}, 4'h1, 4'h2, 4'h3, 4'h4},
    parameter logic [79:0] SENHA_MESTRE = {{12{4'hF}}, {8{4'h9}}},
    parameter int MIN_DIG    = 4,
    parameter int MAX_DIG    = 12,
    parameter int MAX_TENT   = 3,
    parameter int T_ABERTA   = 5000,
    parameter int T_BLOQUEIO = 10000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [79:0] digitos_value,
    input  logic        digitos_valid,
    output logic        teclado_enable,
    output logic        tranca_aberta,
    output logic        senha_erro,
    output logic        prog_ok,
    output logic        modo_prog,
    output logic        bloqueado
);
    localparam int T_MAX = T_ABERTA > T_BLOQUEIO ? T_ABERTA : T_BLOQUEIO;
    localparam int TW = $clog2(T_MAX);
    localparam int FW = $clog2(MAX_TENT + 1);
    localparam logic [4:0] MIN_L = 5'(MIN_DIG);
    localparam logic [4:0] MAX_L = 5'(MAX_DIG);
    typedef enum logic [2:0] {IDLE, AVALIA, ABERTA, BLOQUEIO, PROG, GRAVA} estado_t;
    estado_t estado;
    logic [79:0] senha, pkt, nova;
    logic [FW-1:0] falhas;
    logic [TW-1:0] timer;
    logic [4:0] len;
    logic parar, ok_user, ok_mestre, len_ok, especial;
    // Classification is done on the registered packet so the decision sees a stable entry.
    always_comb begin
        len = '0;
        parar = 1'b0;
        ok_user = 1'b1;
        ok_mestre = 1'b1;
        nova = '1;
        for (int i = 0; i < 20; i++) begin
            if (!parar && pkt[4*i +: 4] != 4'hF) len = len + 5'd1;
            else parar = 1'b1;
            if (senha[4*i +: 4] != 4'hF && senha[4*i +: 4] != pkt[4*i +: 4]) ok_user = 1'b0;
            if (SENHA_MESTRE[4*i +: 4] != 4'hF && SENHA_MESTRE[4*i +: 4] != pkt[4*i +: 4]) ok_mestre = 1'b0;
        end
        for (int i = 0; i < 20; i++)
            nova[4*i +: 4] = 5'(i) < len ? pkt[4*i +: 4] : 4'hF;
        len_ok = len >= MIN_L;
        especial = pkt == {20{4'hE}} || pkt == {20{4'hB}};
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            estado <= IDLE;
            senha <= SENHA_PADRAO;
            pkt <= '1;
            falhas <= '0;
            timer <= '0;
            teclado_enable <= 1'b1;
            tranca_aberta <= 1'b0;
            senha_erro <= 1'b0;
            prog_ok <= 1'b0;
            modo_prog <= 1'b0;
            bloqueado <= 1'b0;
        end else begin
            senha_erro <= 1'b0;
            prog_ok <= 1'b0;
            case (estado)
                IDLE: if (digitos_valid) begin
                    pkt <= digitos_value;
                    estado <= AVALIA;
                end
                PROG: if (digitos_valid) begin
                    pkt <= digitos_value;
                    estado <= GRAVA;
                end
                AVALIA: begin
                    if (especial) estado <= IDLE;
                    else if (ok_mestre && len_ok) begin
                        estado <= PROG;
                        modo_prog <= 1'b1;
                        falhas <= '0;
                    end else if (ok_user && len_ok) begin
                        estado <= ABERTA;
                        tranca_aberta <= 1'b1;
                        teclado_enable <= 1'b0;
                        timer <= '0;
                        falhas <= '0;
                    end else begin
                        senha_erro <= 1'b1;
                        falhas <= falhas + 1'b1;
                        if (falhas == FW'(MAX_TENT - 1)) begin
                            estado <= BLOQUEIO;
                            bloqueado <= 1'b1;
                            teclado_enable <= 1'b0;
                            timer <= '0;
                        end else estado <= IDLE;
                    end
                end
                GRAVA: begin
                    if (especial) begin
                        estado <= IDLE;
                        modo_prog <= 1'b0;
                    end else if (len_ok && len <= MAX_L) begin
                        senha <= nova;
                        prog_ok <= 1'b1;
                        modo_prog <= 1'b0;
                        estado <= IDLE;
                    end else begin
                        senha_erro <= 1'b1;
                        estado <= PROG;
                    end
                end
                ABERTA: begin
                    if (timer == TW'(T_ABERTA - 1)) begin
                        estado <= IDLE;
                        tranca_aberta <= 1'b0;
                        teclado_enable <= 1'b1;
                    end else timer <= timer + 1'b1;
                end
                BLOQUEIO: begin
                    if (timer == TW'(T_BLOQUEIO - 1)) begin
                        estado <= IDLE;
                        bloqueado <= 1'b0;
                        teclado_enable <= 1'b1;
                        falhas <= '0;
                    end else timer <= timer + 1'b1;
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_verificador_senha.sv
// tb_verificador_senha: directed stimulus for the lock controller with hand-derived expectations.
module tb_verificador_senha;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [79:0] digitos_value = '1;
    logic digitos_valid = 1'b0;
    logic teclado_enable, tranca_aberta, senha_erro, prog_ok, modo_prog, bloqueado;
    int n_cmp = 0;
    int n_err = 0;
    verificador_senha dut (
        .clk(clk), .rst(rst),
        .digitos_value(digitos_value), .digitos_valid(digitos_valid),
        .teclado_enable(teclado_enable), .tranca_aberta(tranca_aberta),
        .senha_erro(senha_erro), .prog_ok(prog_ok),
        .modo_prog(modo_prog), .bloqueado(bloqueado)
    );
    always #5 clk = ~clk;
    function automatic logic [79:0] pk(input logic [79:0] d, input int n);
        logic [79:0] r;
        r = '1;
        for (int i = 0; i < n; i++) r[4*i +: 4] = d[4*i +: 4];
        return r;
    endfunction
    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask
    task automatic strobe(input logic [79:0] p);
        @(negedge clk);
        digitos_value = p;
        digitos_valid = 1'b1;
        @(negedge clk);
        digitos_valid = 1'b0;
        digitos_value = '1;
    endtask
    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask
    task automatic erro_pulse(input string tag);
        cyc(1);
        check({tag, "_erro"}, 32'(senha_erro), 1);
        check({tag, "_fechada"}, 32'(tranca_aberta), 0);
        cyc(1);
        check({tag, "_erro_fim"}, 32'(senha_erro), 0);
    endtask
    task automatic abre(input logic [79:0] p, input string tag);
        strobe(p);
        cyc(1);
        check({tag, "_aberta"}, 32'(tranca_aberta), 1);
        check({tag, "_en"}, 32'(teclado_enable), 0);
        cyc(4999);
        check({tag, "_ainda"}, 32'(tranca_aberta), 1);
        cyc(1);
        check({tag, "_fecha"}, 32'(tranca_aberta), 0);
        check({tag, "_en_volta"}, 32'(teclado_enable), 1);
    endtask
    initial begin
        cyc(3);
        check("rst_en", 32'(teclado_enable), 1);
        check("rst_tranca", 32'(tranca_aberta), 0);
        check("rst_erro", 32'(senha_erro), 0);
        check("rst_prog_ok", 32'(prog_ok), 0);
        check("rst_modo", 32'(modo_prog), 0);
        check("rst_bloq", 32'(bloqueado), 0);
        rst = 1'b0;
        cyc(2);
        abre(pk(80'h1234, 4), "padrao");
        abre(pk(80'h561234, 6), "sufixo");
        strobe(pk(80'h123, 3));
        erro_pulse("curta");
        strobe(pk(80'h9999, 4));
        erro_pulse("errada2");
        check("nao_bloq2", 32'(bloqueado), 0);
        abre(pk(80'h1234, 4), "zera");
        strobe(pk(80'h9999, 4));
        erro_pulse("e1");
        strobe(pk(80'h9999, 4));
        erro_pulse("e2");
        check("nao_bloq", 32'(bloqueado), 0);
        strobe(pk(80'h9999, 4));
        cyc(1);
        check("e3_erro", 32'(senha_erro), 1);
        check("bloq", 32'(bloqueado), 1);
        check("bloq_en", 32'(teclado_enable), 0);
        strobe(pk(80'h1234, 4));
        cyc(1);
        check("bloq_ignora", 32'(tranca_aberta), 0);
        check("bloq_ainda", 32'(bloqueado), 1);
        cyc(9996);
        check("bloq_fim_menos1", 32'(bloqueado), 1);
        cyc(1);
        check("bloq_fim", 32'(bloqueado), 0);
        check("bloq_en_volta", 32'(teclado_enable), 1);
        strobe(pk(80'h99999999, 8));
        cyc(1);
        check("mestre_modo", 32'(modo_prog), 1);
        check("mestre_tranca", 32'(tranca_aberta), 0);
        strobe(pk(80'h246810, 6));
        cyc(1);
        check("grava_ok", 32'(prog_ok), 1);
        check("grava_erro", 32'(senha_erro), 0);
        check("grava_modo", 32'(modo_prog), 0);
        cyc(1);
        check("grava_ok_fim", 32'(prog_ok), 0);
        strobe(pk(80'h1234, 4));
        erro_pulse("velha");
        abre(pk(80'h246810, 6), "nova");
        strobe(pk(80'h99999999, 8));
        cyc(1);
        check("mestre2_modo", 32'(modo_prog), 1);
        strobe(pk(80'h12, 2));
        cyc(1);
        check("prog_curta_erro", 32'(senha_erro), 1);
        check("prog_curta_ok", 32'(prog_ok), 0);
        check("prog_curta_modo", 32'(modo_prog), 1);
        strobe({20{4'hB}});
        cyc(1);
        check("cancel_modo", 32'(modo_prog), 0);
        check("cancel_erro", 32'(senha_erro), 0);
        check("cancel_ok", 32'(prog_ok), 0);
        strobe({20{4'hE}});
        cyc(1);
        check("timeout_erro", 32'(senha_erro), 0);
        check("timeout_tranca", 32'(tranca_aberta), 0);
        abre(pk(80'h246810, 6), "mantida");
        strobe(pk(80'h246810, 6));
        cyc(101);
        check("pre_rst_aberta", 32'(tranca_aberta), 1);
        #2 rst = 1'b1;
        #1;
        check("rst_aberta_tranca", 32'(tranca_aberta), 0);
        check("rst_aberta_en", 32'(teclado_enable), 1);
        @(negedge clk) rst = 1'b0;
        strobe(pk(80'h246810, 6));
        erro_pulse("pos_rst_nova");
        strobe(pk(80'h9999, 4));
        erro_pulse("b1");
        strobe(pk(80'h9999, 4));
        cyc(1);
        check("b_bloq", 32'(bloqueado), 1);
        cyc(50);
        #2 rst = 1'b1;
        #1;
        check("rst_bloq_bloq", 32'(bloqueado), 0);
        check("rst_bloq_en", 32'(teclado_enable), 1);
        @(negedge clk) rst = 1'b0;
        strobe(pk(80'h1234, 4));
        cyc(1);
        check("pos_rst_padrao", 32'(tranca_aberta), 1);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
